rom_sample_player: RTL and testbench

// Upstream feeder for Audio_Controller. Steps through a sample ROM at a fixed

---
 rtl/audio_pkg.sv | 29 ++
 rtl/rom_sample_player_if.sv | 22 ++
 rtl/sample_tick_gen.sv | 20 ++
 rtl/rom_sample_player.sv | 111 +++++++++++
 tb/tb_rom_sample_player.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions: player FSM encoding and the 8.8 note step table
// (index 0 is unity pitch, higher indices climb in equal-tempered semitones).
package audio_pkg;
  localparam int STEP_W = 16;
  localparam int FRAC_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_EMIT} state_t;

  function automatic logic [STEP_W-1:0] note_step(input logic [3:0] idx);
    case (idx)
      4'd0:  note_step = 16'h0100;
      4'd1:  note_step = 16'h010F;
      4'd2:  note_step = 16'h011F;
      4'd3:  note_step = 16'h0130;
      4'd4:  note_step = 16'h0143;
      4'd5:  note_step = 16'h0156;
      4'd6:  note_step = 16'h016A;
      4'd7:  note_step = 16'h0180;
      4'd8:  note_step = 16'h0196;
      4'd9:  note_step = 16'h01AF;
      4'd10: note_step = 16'h01C8;
      4'd11: note_step = 16'h01E3;
      4'd12: note_step = 16'h0200;
      4'd13: note_step = 16'h021E;
      4'd14: note_step = 16'h023F;
      4'd15: note_step = 16'h0261;
    endcase
  endfunction
endpackage

// File: rtl/rom_sample_player_if.sv
// ROM read port plus the audio controller write port, bundled for the player.
interface rom_sample_player_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 6
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic              audio_out_allowed;
  logic              write_audio_out;
  logic [31:0]       left_channel_audio_out;
  logic [31:0]       right_channel_audio_out;

  modport master (
    output rom_addr, write_audio_out, left_channel_audio_out, right_channel_audio_out,
    input  rom_q, audio_out_allowed
  );

  modport slave (
    input  rom_addr, write_audio_out, left_channel_audio_out, right_channel_audio_out,
    output rom_q, audio_out_allowed
  );
endinterface

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider: one-clock tick every RATE_DIV+1 clocks.
module sample_tick_gen #(
  parameter int RATE_DIV = 1200
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = (RATE_DIV < 1) ? 1 : $clog2(RATE_DIV + 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(RATE_DIV));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/rom_sample_player.sv
// Phase-accumulator ROM player: fetches one ROM word per sample tick, converts
// it to a left-justified signed sample and offers it to the audio controller.
module rom_sample_player
  import audio_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 6,
  parameter int RATE_DIV    = 1200,
  parameter int ROM_LATENCY = 2
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic                 play,
  input  logic [3:0]           note_sel,
  output logic                 busy,
  rom_sample_player_if.master  bus
);
  localparam int PH_W = ADDR_W + FRAC_W;

  state_t                 state, state_nxt;
  logic [PH_W-1:0]        phase;
  logic [STEP_W-1:0]      step;
  logic [DATA_W-1:0]      sample;
  logic                   pending;
  logic [ROM_LATENCY-1:0] vld_pipe;
  logic                   tick, start, adv, capture, silence, strobe;
  logic                   wr;
  logic [31:0]            word;

  sample_tick_gen #(.RATE_DIV(RATE_DIV)) u_tick (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .tick  (tick)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    adv       = 1'b0;
    capture   = 1'b0;
    silence   = 1'b0;
    case (state)
      S_IDLE:  if (tick && play) begin
                 state_nxt = S_FETCH;
                 start     = 1'b1;
               end
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  if (vld_pipe[ROM_LATENCY-1]) begin
                 state_nxt = S_EMIT;
                 capture   = 1'b1;
               end
      S_EMIT:  if (tick) begin
                 adv = 1'b1;
                 if (play) state_nxt = S_FETCH;
                 else begin
                   state_nxt = S_IDLE;
                   silence   = 1'b1;
                 end
               end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counts ROM read latency from the fetch cycle; the top bit marks valid rom_q.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) vld_pipe <= '0;
    else begin
      vld_pipe[0] <= (state == S_FETCH);
      for (int i = 1; i < ROM_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // A load in the same cycle holds the strobe back one clock so only the newest word goes out.
  assign strobe = pending && bus.audio_out_allowed && !(capture || silence);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      phase   <= '0;
      step    <= '0;
      sample  <= '0;
      pending <= 1'b0;
      wr      <= 1'b0;
      word    <= '0;
    end else begin
      if (start) begin
        step  <= note_step(note_sel);
        phase <= '0;
      end else if (adv) begin
        phase <= phase + PH_W'(step);
        if (play) step <= note_step(note_sel);
      end
      if (capture)      sample <= {~bus.rom_q[DATA_W-1], bus.rom_q[DATA_W-2:0]};
      else if (silence) sample <= '0;
      if (capture || silence) pending <= 1'b1;
      else if (strobe)        pending <= 1'b0;
      wr <= strobe;
      if (strobe) word <= {sample, {(32-DATA_W){1'b0}}};
    end
  end

  assign bus.rom_addr                = phase[PH_W-1:FRAC_W];
  assign bus.write_audio_out         = wr;
  assign bus.left_channel_audio_out  = word;
  assign bus.right_channel_audio_out = word;
  assign busy                        = (state != S_IDLE);
endmodule

// File: tb/tb_rom_sample_player.sv
// Directed bench for rom_sample_player: a full-rate instance for timing/data
// scenarios and a fast-tick instance that runs continuously to the address wrap.
module tb_rom_sample_player;
  logic       clk = 1'b0;
  logic       resetn, resetn_w, play, play_w;
  logic [3:0] note_sel;
  logic       busy, busy_w;
  logic [5:0] rom_xor;
  logic [5:0] q1, q1_w;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         strb = 0;

  always #10 clk = ~clk;

  rom_sample_player_if #(.ADDR_W(14), .DATA_W(6)) bus ();
  rom_sample_player_if #(.ADDR_W(14), .DATA_W(6)) bus_w ();

  rom_sample_player #(.ADDR_W(14), .DATA_W(6), .RATE_DIV(1200), .ROM_LATENCY(2)) u_dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .play     (play),
    .note_sel (note_sel),
    .busy     (busy),
    .bus      (bus)
  );

  rom_sample_player #(.ADDR_W(14), .DATA_W(6), .RATE_DIV(3), .ROM_LATENCY(2)) u_wrap (
    .CLOCK_50 (clk),
    .resetn   (resetn_w),
    .play     (play_w),
    .note_sel (4'd0),
    .busy     (busy_w),
    .bus      (bus_w)
  );

  assign bus_w.audio_out_allowed = 1'b1;

  // Two-stage ROMs: word = low address bits (xor pattern on the main instance).
  always @(posedge clk) begin
    q1          <= bus.rom_addr[5:0] ^ rom_xor;
    bus.rom_q   <= q1;
    q1_w        <= bus_w.rom_addr[5:0];
    bus_w.rom_q <= q1_w;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.write_audio_out) strb <= strb + 1;
  end

  task automatic wait_strobe(input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.write_audio_out) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    int t, s;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    play   = 1'b1;
    wait_strobe(3000, ok, t);
    wait_strobe(1500, ok, t);
    checks++; if (!ok) begin errors++; $display("FAIL reset_prerun: no strobe within budget"); end
    checks++; if (busy !== 1'b1 || bus.left_channel_audio_out !== 32'h8400_0000)
      begin errors++; $display("FAIL reset_prerun_state: busy=%b left=%h want busy=1 left=84000000", busy, bus.left_channel_audio_out); end
    #5 resetn = 1'b0;
    #1;
    checks++; if (bus.rom_addr !== 14'd0) begin errors++; $display("FAIL reset_rom_addr: got %h want 0", bus.rom_addr); end
    checks++; if (bus.write_audio_out !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", bus.write_audio_out); end
    checks++; if (bus.left_channel_audio_out !== 32'h0 || bus.right_channel_audio_out !== 32'h0)
      begin errors++; $display("FAIL reset_audio: got %h/%h want 0/0", bus.left_channel_audio_out, bus.right_channel_audio_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    play = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    s = strb;
    repeat (3700) @(negedge clk);
    checks++; if (strb !== s) begin errors++; $display("FAIL reset_idle_strobes: got %0d want 0", strb - s); end
    checks++; if (busy !== 1'b0 || bus.rom_addr !== 14'd0)
      begin errors++; $display("FAIL reset_idle_state: busy=%b addr=%h want 0/0", busy, bus.rom_addr); end
  endtask

  task automatic test_step_unity();
    logic [31:0] exp_w [4] = '{32'h8000_0000, 32'h8400_0000, 32'h8800_0000, 32'h8C00_0000};
    bit ok;
    int t, ca, prev;
    logic [13:0] pa;
    rom_xor  = 6'h00;
    note_sel = 4'd0;
    play     = 1'b1;
    wait_strobe(1300, ok, t);
    checks++; if (!ok || bus.rom_addr !== 14'd0 || bus.left_channel_audio_out !== exp_w[0] || bus.right_channel_audio_out !== exp_w[0])
      begin errors++; $display("FAIL unity_first: ok=%b addr=%h left=%h right=%h want addr 0 data %h", ok, bus.rom_addr, bus.left_channel_audio_out, bus.right_channel_audio_out, exp_w[0]); end
    prev = t;
    for (int k = 1; k < 4; k++) begin
      pa = bus.rom_addr;
      ok = 1'b0;
      ca = 0;
      for (int i = 0; i < 1300; i++) begin
        @(negedge clk);
        if (bus.rom_addr !== pa) begin ok = 1'b1; ca = cyc; break; end
      end
      checks++; if (!ok || bus.rom_addr !== 14'(k)) begin errors++; $display("FAIL unity_addr%0d: got %h want %h", k, bus.rom_addr, k); end
      wait_strobe(10, ok, t);
      checks++; if (!ok || t - ca != 4) begin errors++; $display("FAIL unity_latency%0d: got %0d want 4", k, t - ca); end
      checks++; if (t - prev != 1201) begin errors++; $display("FAIL unity_spacing%0d: got %0d want 1201", k, t - prev); end
      checks++; if (bus.left_channel_audio_out !== exp_w[k]) begin errors++; $display("FAIL unity_data%0d: got %h want %h", k, bus.left_channel_audio_out, exp_w[k]); end
      prev = t;
    end
  endtask

  task automatic test_stop(input logic [13:0] exp_addr, input string tag);
    bit ok;
    int t, s;
    @(negedge clk);
    s    = strb;
    play = 1'b0;
    wait_strobe(1300, ok, t);
    checks++; if (!ok || bus.left_channel_audio_out !== 32'h0 || bus.right_channel_audio_out !== 32'h0)
      begin errors++; $display("FAIL %s_silence: ok=%b got %h/%h want 0/0", tag, ok, bus.left_channel_audio_out, bus.right_channel_audio_out); end
    checks++; if (bus.rom_addr !== exp_addr) begin errors++; $display("FAIL %s_addr: got %h want %h", tag, bus.rom_addr, exp_addr); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b want 0", tag, busy); end
    repeat (2500) @(negedge clk);
    checks++; if (strb !== s + 1) begin errors++; $display("FAIL %s_count: got %0d want 1", tag, strb - s); end
    checks++; if (bus.rom_addr !== exp_addr) begin errors++; $display("FAIL %s_frozen: got %h want %h", tag, bus.rom_addr, exp_addr); end
  endtask

  task automatic test_step_frac();
    logic [13:0] exp_a [5] = '{14'd0, 14'd1, 14'd3, 14'd4, 14'd6};
    logic [31:0] exp_w [5] = '{32'h8000_0000, 32'h8400_0000, 32'h8C00_0000, 32'h9000_0000, 32'h9800_0000};
    bit ok;
    int t;
    rom_xor  = 6'h00;
    note_sel = 4'd7;
    play     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_strobe(1300, ok, t);
      checks++; if (!ok || bus.rom_addr !== exp_a[k] || bus.left_channel_audio_out !== exp_w[k])
        begin errors++; $display("FAIL frac_%0d: ok=%b addr=%h data=%h want %h/%h", k, ok, bus.rom_addr, bus.left_channel_audio_out, exp_a[k], exp_w[k]); end
    end
    rom_xor = 6'h38;
    wait_strobe(1300, ok, t);
    checks++; if (!ok || bus.rom_addr !== 14'd7 || bus.left_channel_audio_out !== 32'h7C00_0000)
      begin errors++; $display("FAIL frac_max: ok=%b addr=%h data=%h want 7/7c000000", ok, bus.rom_addr, bus.left_channel_audio_out); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int t, s;
    rom_xor  = 6'h00;
    note_sel = 4'd0;
    play     = 1'b1;
    wait_strobe(1300, ok, t);
    checks++; if (!ok || bus.left_channel_audio_out !== 32'h8000_0000)
      begin errors++; $display("FAIL bp_first: ok=%b got %h want 80000000", ok, bus.left_channel_audio_out); end
    bus.audio_out_allowed = 1'b0;
    @(negedge clk);
    s = strb;
    repeat (2999) @(negedge clk);
    checks++; if (strb !== s || bus.left_channel_audio_out !== 32'h8000_0000)
      begin errors++; $display("FAIL bp_hold: strobes=%0d data=%h want 0/80000000", strb - s, bus.left_channel_audio_out); end
    bus.audio_out_allowed = 1'b1;
    wait_strobe(3, ok, t);
    checks++; if (!ok || bus.left_channel_audio_out !== 32'h8800_0000 || bus.rom_addr !== 14'd2)
      begin errors++; $display("FAIL bp_release: ok=%b data=%h addr=%h want 88000000/2", ok, bus.left_channel_audio_out, bus.rom_addr); end
    @(negedge clk);
    s = strb;
    wait_strobe(700, ok, t);
    checks++; if (!ok || strb !== s || bus.left_channel_audio_out !== 32'h8C00_0000)
      begin errors++; $display("FAIL bp_resume: ok=%b extra=%0d data=%h want 8c000000", ok, strb - s, bus.left_channel_audio_out); end
  endtask

  task automatic test_wrap();
    bit ok, extra;
    ok = 1'b0;
    for (int i = 0; i < 80000; i++) begin
      @(negedge clk);
      if (bus_w.rom_addr === 14'd16383) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL wrap_reach: rom_addr=%h want 3fff", bus_w.rom_addr); end
    checks++; if (bus_w.write_audio_out !== 1'b1 || bus_w.left_channel_audio_out !== 32'h7800_0000)
      begin errors++; $display("FAIL wrap_pre: wr=%b data=%h want 1/78000000", bus_w.write_audio_out, bus_w.left_channel_audio_out); end
    extra = 1'b0;
    repeat (3) begin @(negedge clk); if (bus_w.write_audio_out) extra = 1'b1; end
    @(negedge clk);
    checks++; if (bus_w.rom_addr !== 14'd0 || extra) begin errors++; $display("FAIL wrap_addr: got %h extra=%b want 0/0", bus_w.rom_addr, extra); end
    checks++; if (bus_w.write_audio_out !== 1'b1 || bus_w.left_channel_audio_out !== 32'h7C00_0000 || bus_w.right_channel_audio_out !== 32'h7C00_0000)
      begin errors++; $display("FAIL wrap_last: wr=%b data=%h want 1/7c000000", bus_w.write_audio_out, bus_w.left_channel_audio_out); end
    extra = 1'b0;
    repeat (3) begin @(negedge clk); if (bus_w.write_audio_out) extra = 1'b1; end
    @(negedge clk);
    checks++; if (extra || bus_w.write_audio_out !== 1'b1 || bus_w.left_channel_audio_out !== 32'h8000_0000 || bus_w.rom_addr !== 14'd1 || busy_w !== 1'b1)
      begin errors++; $display("FAIL wrap_first: extra=%b wr=%b data=%h addr=%h want 0/1/80000000/1", extra, bus_w.write_audio_out, bus_w.left_channel_audio_out, bus_w.rom_addr); end
  endtask

  initial begin
    resetn                = 1'b0;
    resetn_w              = 1'b0;
    play                  = 1'b0;
    play_w                = 1'b1;
    note_sel              = 4'd0;
    rom_xor               = 6'h00;
    bus.audio_out_allowed = 1'b1;
    repeat (3) @(negedge clk);
    resetn_w = 1'b1;
    test_reset();
    test_step_unity();
    test_stop(14'd4, "unity_stop");
    test_step_frac();
    test_stop(14'd9, "frac_stop");
    rom_xor = 6'h00;
    test_backpressure();
    test_stop(14'd4, "bp_stop");
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
